// File: rtl/asip_pkg.sv
// Shared types and constants for the MAX/MIN/AVG ASIP control path.
// Opcodes A/B are defined here; the control unit only decodes them when CU_LOOP_EN is set.
package asip_pkg;

    localparam int OPW = 4;
    localparam int AW  = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_MAX  = 3'd1,
        ALU_MIN  = 3'd2,
        ALU_ADD  = 3'd3,
        ALU_SHR1 = 3'd4
    } alu_op_t;

    // How EXEC steers the program counter for the latched instruction.
    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_JMP  = 3'd1,
        BR_JZ   = 3'd2,
        BR_HALT = 3'd3,
        BR_LDLC = 3'd4,
        BR_DJNZ = 3'd5
    } br_kind_t;

    localparam logic [OPW-1:0] OP_NOP  = 4'h0;
    localparam logic [OPW-1:0] OP_LDI  = 4'h1;
    localparam logic [OPW-1:0] OP_MAX  = 4'h3;
    localparam logic [OPW-1:0] OP_MIN  = 4'h4;
    localparam logic [OPW-1:0] OP_ADD  = 4'h5;
    localparam logic [OPW-1:0] OP_SHR  = 4'h6;
    localparam logic [OPW-1:0] OP_JMP  = 4'h8;
    localparam logic [OPW-1:0] OP_JZ   = 4'h9;
    localparam logic [OPW-1:0] OP_DJNZ = 4'hA;
    localparam logic [OPW-1:0] OP_LDLC = 4'hB;
    localparam logic [OPW-1:0] OP_HALT = 4'hF;

endpackage

// File: rtl/asip_decoder.sv
// Combinational opcode decoder: ALU operation, register write enable and branch kind.
// Loop opcodes A/B are recognised only when CU_LOOP_EN is defined.
module asip_decoder
    import asip_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output alu_op_t        alu_op,
    output logic           we,
    output br_kind_t       br_kind
);

    always_comb begin
        alu_op  = ALU_PASS;
        we      = 1'b0;
        br_kind = BR_NONE;
        case (opcode)
            OP_LDI:  begin alu_op = ALU_PASS; we = 1'b1; end
            OP_MAX:  begin alu_op = ALU_MAX;  we = 1'b1; end
            OP_MIN:  begin alu_op = ALU_MIN;  we = 1'b1; end
            OP_ADD:  begin alu_op = ALU_ADD;  we = 1'b1; end
            OP_SHR:  begin alu_op = ALU_SHR1; we = 1'b1; end
            OP_JMP:  br_kind = BR_JMP;
            OP_JZ:   br_kind = BR_JZ;
            OP_HALT: br_kind = BR_HALT;
`ifdef CU_LOOP_EN
            OP_LDLC: br_kind = BR_LDLC;
            OP_DJNZ: br_kind = BR_DJNZ;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/asip_control_unit.sv
// Fetch/decode/execute sequencer for the ASIP; drives PC controls and one-cycle EXEC strobes.
// Define CU_LOOP_EN to add the LC loop counter with LDLC (B) and DJNZ (A).
module asip_control_unit
    import asip_pkg::*;
(
    input  logic           CLK,
    input  logic           RESET,
    input  logic           START,
    input  logic [15:0]    IMEM_data,
    input  logic           IMEM_valid,
    input  logic           ZERO_flag,
    output logic           IMEM_req,
    output logic           PC_load,
    output logic           PC_inc,
    output logic [AW-1:0]  PC_in,
    output logic [15:0]    IR_out,
    output logic [2:0]     ALU_op,
    output logic [3:0]     REG_sel,
    output logic           REG_we,
    output logic           HALTED
);

    state_t   state;
    alu_op_t  dec_alu;
    logic     dec_we;
    br_kind_t dec_br;
    alu_op_t  alu_r;
    logic     we_r;
    br_kind_t br_r;

`ifdef CU_LOOP_EN
    logic [AW-1:0] lc;
    logic [AW-1:0] lc_dec;
    assign lc_dec = lc - {{(AW-1){1'b0}}, 1'b1};
`endif

    asip_decoder u_dec (
        .opcode  (IR_out[15:12]),
        .alu_op  (dec_alu),
        .we      (dec_we),
        .br_kind (dec_br)
    );

    assign ALU_op = alu_r;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            IMEM_req <= 1'b0;
            IR_out   <= '0;
            alu_r    <= ALU_PASS;
            REG_sel  <= '0;
            PC_in    <= '0;
            we_r     <= 1'b0;
            br_r     <= BR_NONE;
            HALTED   <= 1'b0;
`ifdef CU_LOOP_EN
            lc       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state    <= S_FETCH;
                        IMEM_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (IMEM_valid) begin
                        IR_out   <= IMEM_data;
                        IMEM_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_r   <= dec_alu;
                    we_r    <= dec_we;
                    br_r    <= dec_br;
                    REG_sel <= IR_out[11:8];
                    PC_in   <= IR_out[AW-1:0];
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    if (br_r == BR_HALT) begin
                        state  <= S_HALT;
                        HALTED <= 1'b1;
                    end else begin
                        state    <= S_FETCH;
                        IMEM_req <= 1'b1;
                    end
`ifdef CU_LOOP_EN
                    if (br_r == BR_LDLC)
                        lc <= PC_in;
                    else if (br_r == BR_DJNZ)
                        lc <= lc_dec;
`endif
                end
                S_HALT: ;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are decoded from registered fields; only JZ adds a live ZERO_flag term in EXEC.
    always_comb begin
        PC_load = 1'b0;
        PC_inc  = 1'b0;
        REG_we  = 1'b0;
        if (state == S_EXEC) begin
            REG_we = we_r;
            case (br_r)
                BR_NONE: PC_inc  = 1'b1;
                BR_JMP:  PC_load = 1'b1;
                BR_JZ: begin
                    if (ZERO_flag) PC_load = 1'b1;
                    else           PC_inc  = 1'b1;
                end
`ifdef CU_LOOP_EN
                BR_LDLC: PC_inc = 1'b1;
                BR_DJNZ: begin
                    if (lc_dec != '0) PC_load = 1'b1;
                    else              PC_inc  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_asip_control_unit.sv
// Directed bench for asip_control_unit; loop-counter steps build only with CU_LOOP_EN.
module tb_asip_control_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [15:0] IMEM_data;
    logic        IMEM_valid;
    logic        ZERO_flag;
    logic        IMEM_req;
    logic        PC_load;
    logic        PC_inc;
    logic [7:0]  PC_in;
    logic [15:0] IR_out;
    logic [2:0]  ALU_op;
    logic [3:0]  REG_sel;
    logic        REG_we;
    logic        HALTED;

    int vectors = 0;
    int errors  = 0;
    int reqcnt;
    int wecnt;

    always #5 CLK = ~CLK;

    asip_control_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .START      (START),
        .IMEM_data  (IMEM_data),
        .IMEM_valid (IMEM_valid),
        .ZERO_flag  (ZERO_flag),
        .IMEM_req   (IMEM_req),
        .PC_load    (PC_load),
        .PC_inc     (PC_inc),
        .PC_in      (PC_in),
        .IR_out     (IR_out),
        .ALU_op     (ALU_op),
        .REG_sel    (REG_sel),
        .REG_we     (REG_we),
        .HALTED     (HALTED)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of an EXEC cycle; returns at the negedge of the next EXEC.
    // IMEM_valid is raised after wt FETCH cycles without it.
    task automatic run_instr(input logic [15:0] w, input int wt, output int nreq, output int nwe);
        bit seen = 1'b0;
        IMEM_data  = w;
        IMEM_valid = 1'b0;
        nreq = 0;
        nwe  = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (REG_we) nwe++;
            if (IMEM_req) begin
                seen = 1'b1;
                nreq++;
                if (nreq == wt + 1) IMEM_valid = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        IMEM_valid = 1'b0;
        @(negedge CLK);
    endtask

    task automatic chk_strobes(input string tag, input logic ld, input logic inc, input logic we);
        chk({tag, "_load"}, {31'd0, PC_load}, {31'd0, ld});
        chk({tag, "_inc"},  {31'd0, PC_inc},  {31'd0, inc});
        chk({tag, "_we"},   {31'd0, REG_we},  {31'd0, we});
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; IMEM_data = '0; IMEM_valid = 1'b0; ZERO_flag = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_req", {31'd0, IMEM_req}, 32'd0);
        chk("rst_ir", {16'd0, IR_out}, 32'd0);
        chk("rst_pcin", {24'd0, PC_in}, 32'd0);
        chk("rst_halted", {31'd0, HALTED}, 32'd0);
        chk_strobes("rst", 1'b0, 1'b0, 1'b0);

        // LDI r3, 0x05 with memory always ready
        RESET = 1'b0; START = 1'b1; IMEM_valid = 1'b1; IMEM_data = 16'h1305;
        chk("start_req_before", {31'd0, IMEM_req}, 32'd0);
        @(negedge CLK);
        START = 1'b0;
        chk("start_req_rise", {31'd0, IMEM_req}, 32'd1);
        @(negedge CLK);
        chk("ldi_decode_req", {31'd0, IMEM_req}, 32'd0);
        chk("ldi_ir", {16'd0, IR_out}, 32'h1305);
        @(negedge CLK);
        chk_strobes("ldi", 1'b0, 1'b1, 1'b1);
        chk("ldi_sel", {28'd0, REG_sel}, 32'd3);
        chk("ldi_alu", {29'd0, ALU_op}, 32'd0);

        // MAX r1 with four wait states
        run_instr(16'h3100, 4, reqcnt, wecnt);
        chk("max_reqcnt", reqcnt, 32'd5);
        chk("ldi_we_single", wecnt, 32'd0);
        chk_strobes("max", 1'b0, 1'b1, 1'b1);
        chk("max_alu", {29'd0, ALU_op}, 32'd1);
        chk("max_sel", {28'd0, REG_sel}, 32'd1);

        run_instr(16'h4200, 0, reqcnt, wecnt);
        chk("min_alu", {29'd0, ALU_op}, 32'd2);
        chk("max_we_single", wecnt, 32'd0);
        run_instr(16'h5700, 1, reqcnt, wecnt);
        chk("add_alu", {29'd0, ALU_op}, 32'd3);
        chk("add_reqcnt", reqcnt, 32'd2);
        run_instr(16'h6500, 0, reqcnt, wecnt);
        chk("shr_alu", {29'd0, ALU_op}, 32'd4);
        chk("shr_sel", {28'd0, REG_sel}, 32'd5);
        chk_strobes("shr", 1'b0, 1'b1, 1'b1);

        run_instr(16'h8042, 0, reqcnt, wecnt);
        chk_strobes("jmp", 1'b1, 1'b0, 1'b0);
        chk("jmp_pcin", {24'd0, PC_in}, 32'h42);

        run_instr(16'h9010, 0, reqcnt, wecnt);
        chk_strobes("jz_nz", 1'b0, 1'b1, 1'b0);
        ZERO_flag = 1'b1;
        run_instr(16'h9077, 0, reqcnt, wecnt);
        chk_strobes("jz_z", 1'b1, 1'b0, 1'b0);
        chk("jz_pcin", {24'd0, PC_in}, 32'h77);
        ZERO_flag = 1'b0;

        run_instr(16'h2ABC, 0, reqcnt, wecnt);
        chk_strobes("undef_op", 1'b0, 1'b1, 1'b0);
        run_instr(16'h0000, 0, reqcnt, wecnt);
        chk_strobes("nop", 1'b0, 1'b1, 1'b0);

`ifdef CU_LOOP_EN
        run_instr(16'hB003, 0, reqcnt, wecnt);
        chk_strobes("ldlc", 1'b0, 1'b1, 1'b0);
        run_instr(16'hA020, 0, reqcnt, wecnt);
        chk_strobes("djnz1", 1'b1, 1'b0, 1'b0);
        chk("djnz_pcin", {24'd0, PC_in}, 32'h20);
        run_instr(16'hA020, 0, reqcnt, wecnt);
        chk_strobes("djnz2", 1'b1, 1'b0, 1'b0);
        run_instr(16'hA020, 0, reqcnt, wecnt);
        chk_strobes("djnz3", 1'b0, 1'b1, 1'b0);
        run_instr(16'hA020, 0, reqcnt, wecnt);
        chk_strobes("djnz_wrap", 1'b1, 1'b0, 1'b0);
`else
        run_instr(16'hB003, 0, reqcnt, wecnt);
        chk_strobes("op_b_nop", 1'b0, 1'b1, 1'b0);
        run_instr(16'hA020, 0, reqcnt, wecnt);
        chk_strobes("op_a_nop", 1'b0, 1'b1, 1'b0);
`endif

        run_instr(16'hF000, 0, reqcnt, wecnt);
        chk_strobes("halt_exec", 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("halted", {31'd0, HALTED}, 32'd1);
        chk("halt_req", {31'd0, IMEM_req}, 32'd0);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (2) @(negedge CLK);
        chk("halt_start_req", {31'd0, IMEM_req}, 32'd0);
        chk("halt_start_halted", {31'd0, HALTED}, 32'd1);
        chk_strobes("halt_idle", 1'b0, 1'b0, 1'b0);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("halt_reset", {31'd0, HALTED}, 32'd0);

        // Reset while a valid word is pending in FETCH
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        chk("mid_fetch_req", {31'd0, IMEM_req}, 32'd1);
        IMEM_data = 16'h5123; IMEM_valid = 1'b1; RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0; IMEM_valid = 1'b0;
        chk("midrst_ir", {16'd0, IR_out}, 32'd0);
        chk("midrst_req", {31'd0, IMEM_req}, 32'd0);
        chk_strobes("midrst", 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        chk("midrst_idle", {31'd0, IMEM_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
